vec_product_feeder: RTL and testbench



---
 rtl/vec_product_feeder.sv | 96 +++++++++
 tb/tb_vec_product_feeder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/vec_product_feeder.sv
// vec_product_feeder: streams A[i]*B[i] or A[i]^B[i] from two operand RAMs over valid/ready
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   wr_en/wr_sel/wr_addr/wr_data  operand RAM write port (A when wr_sel=0, B when 1), IDLE only
//   start/op_xor                  begin a stream; op_xor latched at start (0 multiply, 1 xor)
//   busy                          high outside IDLE
//   out_valid/out_ready/out_data/out_last  element result stream, last flags element N-1
//   done                          one-cycle pulse after the last word is accepted
module vec_product_feeder #(
    parameter int N  = 16,
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          start,
    input  logic          op_xor,
    output logic          busy,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [2*DW-1:0] out_data,
    output logic          out_last,
    output logic          done
);
    localparam int OW = 2 * DW;
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    typedef enum logic [2:0] {IDLE, RD, CAP, STREAM, DONE} state_t;

    state_t        state;
    logic [AW-1:0] idx;
    logic          op_q;
    logic [DW-1:0] ram_a [N];
    logic [DW-1:0] ram_b [N];
    logic [DW-1:0] q_a, q_b;
    logic [OW-1:0] result;

    // RAM contents survive reset; the read port is sampled every cycle and is consumed in CAP.
    always_ff @(posedge clk) begin
        if (wr_en && state == IDLE && !wr_sel) ram_a[wr_addr] <= wr_data;
        if (wr_en && state == IDLE && wr_sel) ram_b[wr_addr] <= wr_data;
        q_a <= ram_a[idx];
        q_b <= ram_b[idx];
    end

    always_comb result = op_q ? {{DW{1'b0}}, q_a ^ q_b} : OW'(q_a) * OW'(q_b);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            idx       <= '0;
            op_q      <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    idx   <= '0;
                    op_q  <= op_xor;
                    busy  <= 1'b1;
                    state <= RD;
                end
                RD: state <= CAP;
                CAP: begin
                    out_data  <= result;
                    out_last  <= idx == LAST;
                    out_valid <= 1'b1;
                    state     <= STREAM;
                end
                STREAM: if (out_ready) begin
                    out_valid <= 1'b0;
                    if (idx == LAST) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= RD;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vec_product_feeder.sv
// tb_vec_product_feeder: table-driven and randomized self-checking bench for vec_product_feeder
module tb_vec_product_feeder;
    logic        clk = 0, reset = 0;
    logic        wr_en = 0, wr_sel = 0, start = 0, op_xor = 0, out_ready = 1;
    logic [3:0]  wr_addr = 0;
    logic [7:0]  wr_data = 0;
    logic        busy, out_valid, out_last, done;
    logic [15:0] out_data;

    int checks = 0, failures = 0;
    logic [7:0]  ma [16];
    logic [7:0]  mb [16];
    logic [31:0] sum;
    logic [15:0] first_w, last_w;
    int nw, nd;

    typedef struct {
        logic        op;
        logic [7:0]  a0, astep, b;
        logic [15:0] first, last;
        logic [31:0] sum;
    } vec_t;
    vec_t tbl [3];

    vec_product_feeder #(.N(16), .DW(8), .AW(4)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .op_xor(op_xor), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic op);
        int p;
        p = op ? int'(a ^ b) : int'(a) * int'(b);
        return p[15:0];
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic sel, input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_en = 1; wr_sel = sel; wr_addr = a; wr_data = d;
        if (sel) mb[a] = d; else ma[a] = d;
        @(posedge clk);
        #1 wr_en = 0;
    endtask

    // Pulses start (optionally with a same-cycle write to A) and checks the first two cycles.
    task automatic go(input logic op, input bit w, input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        start = 1; op_xor = op; out_ready = 1;
        if (w) begin
            wr_en = 1; wr_sel = 0; wr_addr = a; wr_data = d; ma[a] = d;
        end
        @(negedge clk);
        start = 0; wr_en = 0;
        check("busy_after_start", busy, 1);
        check("valid_lat1", out_valid, 0);
        @(negedge clk);
        check("valid_lat2", out_valid, 0);
    endtask

    task automatic collect(input logic op, input int stall_word, input int stall_len, input bit rnd,
                           input int poke_word, input int abort_word);
        int budget = 0, stall = 0;
        bit hold = 0, poked = 0, aborted = 0;
        logic [15:0] held = 0;
        nw = 0; nd = 0; sum = 0;
        while (budget < 600) begin
            @(negedge clk);
            budget++;
            wr_en = 0; start = 0;
            op_xor = 1'($urandom);
            if (budget == 1) check("valid_lat3", out_valid, 1);
            if (hold) check("hold_word", {out_valid, out_data}, {1'b1, held});
            if (done) begin nd++; break; end
            if (abort_word >= 0 && nw == abort_word && out_valid) begin
                reset = 0;
                #1 check("async_rst_outs", {busy, out_valid, out_data, out_last, done}, 0);
                @(negedge clk);
                check("rst_hold_outs", {busy, out_valid, out_data, out_last, done}, 0);
                reset = 1;
                aborted = 1;
                break;
            end
            if (poke_word >= 0 && nw == poke_word && !poked) begin
                poked = 1;
                wr_en = 1; wr_sel = 0; wr_addr = 0; wr_data = ~ma[0]; start = 1;
            end
            if (out_valid && nw == stall_word && stall < stall_len) begin
                out_ready = 0;
                stall++;
            end else out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            hold = out_valid && !out_ready;
            held = out_data;
            if (out_valid && out_ready) begin
                if (nw >= 16) check("extra_word", nw, 15);
                else begin
                    check($sformatf("word%0d", nw), out_data, model(ma[nw], mb[nw], op));
                    check($sformatf("last%0d", nw), out_last, nw == 15);
                    if (nw == 0) first_w = out_data;
                    last_w = out_data;
                    sum += 32'(out_data);
                end
                nw++;
            end
        end
        if (budget >= 600) check("timeout", budget, 0);
        if (!aborted) begin
            @(negedge clk);
            check("done_one_cycle", done, 0);
            check("busy_cleared", busy, 0);
        end
        out_ready = 1; wr_en = 0; start = 0;
    endtask

    task automatic load(input logic [7:0] a0, input logic [7:0] astep, input logic [7:0] b);
        for (int i = 0; i < 16; i++) begin
            wr(0, 4'(i), 8'(a0 + astep * 8'(i)));
            wr(1, 4'(i), b);
        end
    endtask

    initial begin
        logic [31:0] msum;
        logic        op;
        tbl[0] = '{1'b0, 8'd1, 8'd1, 8'd2, 16'h0002, 16'h0020, 32'h110};
        tbl[1] = '{1'b1, 8'd0, 8'd1, 8'hFF, 16'h00FF, 16'h00F0, 32'hF78};
        tbl[2] = '{1'b0, 8'hFF, 8'd0, 8'hFF, 16'hFE01, 16'hFE01, 32'hFE010};
        repeat (3) @(negedge clk);
        check("reset_outs", {busy, out_valid, out_data, out_last, done}, 0);
        reset = 1;
        for (int t = 0; t < 3; t++) begin
            load(tbl[t].a0, tbl[t].astep, tbl[t].b);
            go(tbl[t].op, 0, 0, 0);
            collect(tbl[t].op, -1, 0, 0, -1, -1);
            check("tbl_count", nw, 16);
            check("tbl_done", nd, 1);
            check("tbl_first", first_w, tbl[t].first);
            check("tbl_last", last_w, tbl[t].last);
            check("tbl_sum", sum, tbl[t].sum);
        end
        // start and A[0] write attempted mid-stream must be ignored; rerun must match
        for (int r = 0; r < 2; r++) begin
            go(0, 0, 0, 0);
            collect(0, -1, 0, 0, r == 0 ? 5 : -1, -1);
            check("poke_count", nw, 16);
            check("poke_sum", sum, 32'hFE010);
        end
        load(8'd1, 8'd1, 8'd2);
        go(0, 0, 0, 0);
        collect(0, 3, 5, 0, -1, -1);
        check("stall_count", nw, 16);
        check("stall_sum", sum, 32'h110);
        go(0, 0, 0, 0);
        collect(0, -1, 0, 0, -1, 7);
        check("abort_words", nw, 7);
        check("abort_no_done", nd, 0);
        @(negedge clk);
        check("abort_idle", {busy, out_valid, done}, 0);
        go(0, 0, 0, 0);
        collect(0, -1, 0, 0, -1, -1);
        check("restart_count", nw, 16);
        check("restart_sum", sum, 32'h110);
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 16; i++) begin
                wr(0, 4'(i), 8'($urandom));
                wr(1, 4'(i), 8'($urandom));
            end
            op = 1'($urandom);
            go(op, 1, 4'd15, 8'($urandom));
            collect(op, int'($urandom_range(0, 15)), int'($urandom_range(0, 6)), 1, -1, -1);
            msum = 0;
            for (int i = 0; i < 16; i++) msum += 32'(model(ma[i], mb[i], op));
            check("rnd_count", nw, 16);
            check("rnd_done", nd, 1);
            check("rnd_sum", sum, msum);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
